mem_arbiter: RTL and testbench

Shares the single unified memory port of the RV32IMA `system` between the instruction-fetch requester and the data-access (load/store/AMO) requester of the datapath. Each requester sees a private req/ack channel. The arbiter grants one at a time, holds the grant until the memory acknowledges, and then re-arbitrates. Data access has priority, ifetch has a starvation guard, and AMO read-modify-write sequences can lock the port.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the requester channels and the memory bus of mem_arbiter.
// The arbiter connects through 'slave'; requesters and memory sit on 'master'.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    output d_rdata, d_ack,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    input  d_rdata, d_ack,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (data priority, ifetch starvation guard) for one memory port.
// Define MEM_ARB_LOCK_EN to let d_lock keep the port across an AMO read-modify-write.
module mem_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);
  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       lock_hold;

  // Arbitration uses the post-update count so a grant decision sees the
  // transfer completing on the same edge.
  function automatic state_e arbitrate(input logic d_req, input logic if_req,
                                       input logic [3:0] starve);
    if (d_req && (starve < STARVE_LIM)) return GNT_D;
    else if (if_req)                    return GNT_I;
    else                                return IDLE;
  endfunction

  always_comb begin
`ifdef MEM_ARB_LOCK_EN
    lock_hold = (state_q == GNT_D) && bus.mem_ack && bus.d_lock;
`else
    lock_hold = 1'b0;
`endif
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req)
      starve_d = '0;
    else if ((state_q == GNT_I) && bus.mem_ack)
      starve_d = '0;
    else if ((state_q == GNT_D) && bus.mem_ack && (starve_q < STARVE_LIM))
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        state_d = arbitrate(bus.d_req, bus.if_req, starve_d);
      GNT_I, GNT_D: begin
        if (lock_hold)
          state_d = GNT_D;
        else if (bus.mem_ack)
          state_d = arbitrate(bus.d_req, bus.if_req, starve_d);
      end
      default:
        state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Request bus follows the grant; an ifetch is always a full-word read.
  always_comb begin
    bus.mem_req   = (state_q == GNT_I) || (state_q == GNT_D);
    bus.mem_we    = 1'b0;
    bus.mem_be    = {BE_W{1'b1}};
    bus.mem_addr  = bus.if_addr;
    bus.mem_wdata = '0;
    if (state_q == GNT_D) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    bus.if_ack   = bus.mem_ack && (state_q == GNT_I);
    bus.d_ack    = bus.mem_ack && (state_q == GNT_D);
    bus.if_rdata = bus.mem_rdata;
    bus.d_rdata  = bus.mem_rdata;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, ifetch, store, starvation, lock, mid-transfer reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] grant_now();
    if (bus.d_ack)       return "D";
    else if (bus.if_ack) return "I";
    else                 return "-";
  endfunction

  task automatic test_reset();
    nrst = 1'b0; bus.if_req = 1'b1; bus.d_req = 1'b1;
    bus.if_addr = 32'h10; bus.d_addr = 32'h200; bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
        failures++;
        $display("FAIL rst_hold cyc=%0d got req/iack/dack=%b%b%b exp=000",
                 i, bus.mem_req, bus.if_ack, bus.d_ack);
      end
    end
    nrst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_release_idle got=%b exp=0", bus.mem_req);
    end
    cyc();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL rst_first_grant got req=%b addr=%h exp req=1 addr=00000200",
               bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1; bus.d_req = 1'b0; bus.if_req = 1'b0;
    #1;
    checks++;
    if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_first_ack got dack=%b iack=%b exp 1 0", bus.d_ack, bus.if_ack);
    end
    cyc();
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_back_idle got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_single_ifetch();
    int pulses = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010; bus.mem_rdata = 32'hDEAD_BEEF;
    bus.d_req = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin bus.mem_ack = 1'b1; bus.if_req = 1'b0; end
      #1;
      if (bus.if_ack === 1'b1) pulses++;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 ||
          bus.mem_be !== 4'hF || bus.mem_wdata !== 32'h0) begin
        failures++;
        $display("FAIL ifetch_bus k=%0d got req=%b addr=%h we=%b be=%h wd=%h exp 1 00000010 0 f 00000000",
                 k, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata);
      end
      checks++;
      if (bus.if_ack !== (k == 2) || bus.d_ack !== 1'b0) begin
        failures++;
        $display("FAIL ifetch_ack k=%0d got iack=%b dack=%b exp iack=%b dack=0",
                 k, bus.if_ack, bus.d_ack, (k == 2));
      end
      cyc();
    end
    checks++;
    if (bus.if_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ifetch_rdata got=%h exp=deadbeef", bus.if_rdata);
    end
    bus.mem_ack = 1'b0;
    #1;
    if (bus.if_ack === 1'b1) pulses++;
    checks++;
    if (bus.mem_req !== 1'b0 || pulses != 1) begin
      failures++;
      $display("FAIL ifetch_done got req=%b pulses=%0d exp req=0 pulses=1", bus.mem_req, pulses);
    end
  endtask

  task automatic test_store();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h100;
    bus.d_wdata = 32'h1234_5678; bus.d_lock = 1'b0;
    cyc();
    bus.mem_ack = 1'b1; bus.d_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011 ||
        bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL store_bus got req=%b we=%b be=%b addr=%h wd=%h exp 1 1 0011 00000100 12345678",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL store_ack got dack=%b iack=%b exp 1 0", bus.d_ack, bus.if_ack);
    end
    cyc();
    bus.mem_ack = 1'b0; bus.d_we = 1'b0;
    #1;
    checks++;
    if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL store_done got dack=%b req=%b exp 0 0", bus.d_ack, bus.mem_req);
    end
  endtask

  task automatic test_starvation();
    string      exp_seq = "DDDDIDDDDI";
    logic [7:0] g;
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.if_addr = 32'h40; bus.d_addr = 32'h80;
    bus.mem_ack = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin bus.if_req = 1'b0; bus.d_req = 1'b0; end
      #1;
      g = grant_now();
      checks++;
      if (g !== exp_seq[i]) begin
        failures++;
        $display("FAIL starve_seq slot=%0d got=%s exp=%s", i, g, exp_seq[i]);
      end
      cyc();
    end
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL starve_idle got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_lock();
    logic [5:0] d_req_v, lock_v, we_v, if_req_v;
    string      exp_seq;
    logic [7:0] g;
`ifdef MEM_ARB_LOCK_EN
    d_req_v = 6'b001111; we_v = 6'b110000; exp_seq = "DDDDDI";
`else
    d_req_v = 6'b011111; we_v = 6'b110000; exp_seq = "DDDDID";
`endif
    lock_v   = 6'b001000;
    if_req_v = 6'b011111;
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_lock = 1'b0; bus.d_we = 1'b0;
    bus.mem_ack = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      bus.d_req = d_req_v[i]; bus.d_lock = lock_v[i];
      bus.d_we = we_v[i]; bus.if_req = if_req_v[i];
      #1;
      g = grant_now();
      checks++;
      if (g !== exp_seq[i]) begin
        failures++;
        $display("FAIL lock_seq slot=%0d got=%s exp=%s", i, g, exp_seq[i]);
      end
      cyc();
    end
    bus.mem_ack = 1'b0; bus.d_lock = 1'b0; bus.d_we = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL lock_idle got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_reset_mid();
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.mem_ack = 1'b0;
    cyc();
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL midrst_busy got=%b exp=1", bus.mem_req);
    end
    cyc();
    nrst = 1'b1; bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL midrst_late_ack got req/iack/dack=%b%b%b exp=000",
               bus.mem_req, bus.if_ack, bus.d_ack);
    end
    cyc();
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.d_ack !== 1'b0) begin
      failures++;
      $display("FAIL midrst_resume got req=%b addr=%h dack=%b exp 1 00000300 0",
               bus.mem_req, bus.mem_addr, bus.d_ack);
    end
    bus.mem_ack = 1'b1; bus.d_req = 1'b0;
    #1;
    checks++;
    if (bus.d_ack !== 1'b1) begin
      failures++; $display("FAIL midrst_ack got=%b exp=1", bus.d_ack);
    end
    cyc();
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got=%b exp=0", bus.mem_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_lock = 1'b0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    test_reset();
    test_single_ifetch();
    test_store();
    test_starvation();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
